bounce_gen: RTL and testbench
=============================

# bounce_gen

Synthetic switch-bounce generator: on command it drives a single-bit output through a pseudo-random burst of glitches and then settles at a requested level. It is the stimulus end of the debounce path and feeds `db_fsm` (or the raw edge detector) in on-board self-test builds, replacing the physical push-button. A free-running transition counter lets the bench or display compare raw edges against debounced edges.

## Interface

Parameters:
- `NB`, 4: number of bounce pairs per operation; each operation produces 2*NB glitch toggles. Legal range 0..15.
- `SEG_W`, 4: width of the segment-length field. Each segment lasts 1..2^SEG_W cycles. Legal range 1..16.
- `SETTLE_CYC`, 1024: cycles the final level is held before the operation completes. Must be ≥1.
- `SEED`, 16'hACE1: LFSR reset value. Must be nonzero.

Ports:
- `clk`  in  1  system clock; all logic is rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `level`  in  1  target final level; sampled with `start`.
- `sw_out`  out  1  emulated bouncy switch output.
- `busy`  out  1  high from the cycle after an accepted start until completion.
- `done`  out  1  one-cycle completion pulse.
- `edge_cnt`  out  8  total `sw_out` transitions since reset.

## Operation

- States: IDLE, BOUNCE, SETTLE.
- LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, shifting left with the feedback bit entering at bit 0.
  - Advances exactly once per segment load and is otherwise frozen, so the sequence is deterministic per operation.
  - Segment length L = `lfsr[SEG_W-1:0]` + 1, taken from the pre-advance value.
- IDLE: `sw_out` holds its value.
  - When `start`=1, latch `level` into `tgt`, load segment 0, and zero the toggle counter. Go to BOUNCE.
- BOUNCE: `sw_out` is held stable for the current segment's L cycles.
  - At segment end, if the toggle count is below 2*NB: toggle `sw_out`, increment the toggle count, and load the next segment.
  - At the end of the segment that follows toggle 2*NB: set `sw_out` to `tgt`, load the settle counter with SETTLE_CYC, and go to SETTLE.
  - This final assignment is a transition only if `tgt` differs from the current value.
- SETTLE: `sw_out` = `tgt` is held for SETTLE_CYC cycles. Then go to IDLE with `done`=1 for that cycle and `busy`=0.
- Toggle pattern: 2*NB toggles return `sw_out` to its pre-start value.
  - Transitions per operation = 2*NB + (`tgt` != pre-start value).
  - With NB=0, the operation is one segment, then `tgt`, then settle.
- `start` while `busy`=1 is ignored. No queuing, and `level` is not re-sampled.
- `edge_cnt` increments on every cycle in which `sw_out` changes. It is 8-bit and wraps 255 to 0. Only reset clears it.
- Reset (any time, including mid-operation):
  - `sw_out`=0, `busy`=0, `done`=0, `edge_cnt`=0.
  - State IDLE, LFSR=SEED, and all internal counters 0.

## Timing

- `start` accepted at edge t0, so `busy`=1 from t0+1.
- Segment i covers the cycles t_i .. t_i+L_i-1, with t_0 = t0+1. The new `sw_out` value appears at t_i+L_i.
- The final level appears at t_F = t0+1+ΣL_i (i=0..2*NB). It is held through t_F+SETTLE_CYC-1.
- `done`=1 and `busy`=0 occur at t_F+SETTLE_CYC.
- Total busy cycles = ΣL_i + SETTLE_CYC.
- A new `start` is accepted in the same cycle `done`=1 is asserted.
- All outputs are registered with no combinational path from inputs.
- `edge_cnt` updates in the same cycle `sw_out` changes.

## Test plan

All scenarios use NB=2, SEG_W=3, SETTLE_CYC=16, and SEED=16'hACE1. A bench reference model of the LFSR predicts every L_i.

- Reset: hold `reset_n`=0 → `sw_out`=0, `busy`=0, `done`=0, `edge_cnt`=0. Release: outputs stay unchanged with no `start`.
- `start`, `level`=1 from `sw_out`=0 → exactly 5 transitions at the model-predicted cycles, final `sw_out`=1, `edge_cnt`=5. One `done` pulse at t0+1+ΣL_i(5 segments)+16.
- `start`, `level`=1 with `sw_out` already 1 → exactly 4 glitches (1→0→1→0→1), final 1, `edge_cnt` +4, `done` timing per the model.
- `start` pulsed with `level`=0 at t0+3 during an active operation → ignored. Transition count, final level and `done` time are identical to an undisturbed run.
- Assert `reset_n`=0 mid-BOUNCE with `sw_out`=1 → immediately `sw_out`=0, `busy`=0, `edge_cnt`=0, and no `done`. After release, the next operation reproduces the first operation's segment lengths, since the LFSR is reseeded.
- 52 back-to-back operations alternating `level` 1,0,1,… (5 edges each, 260 total) → `edge_cnt`=4 after wrap. Final `sw_out`=0.

Source files
------------

// File: rtl/bounce_gen.sv
// Synthetic switch-bounce generator: on start, drives sw_out through 2*NB
// LFSR-timed glitches, lands on the requested level, then holds it to settle.
module bounce_gen #(
   parameter int          NB         = 4,
   parameter int          SEG_W      = 4,
   parameter int          SETTLE_CYC = 1024,
   parameter logic [15:0] SEED       = 16'hACE1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic       level,
   output logic       sw_out,
   output logic       busy,
   output logic       done,
   output logic [7:0] edge_cnt
);

   localparam int              TOG_W   = 5;
   localparam logic [TOG_W-1:0] TOG_MAX = TOG_W'(2 * NB);
   localparam int              ST_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [ST_W-1:0] ST_LOAD = ST_W'(SETTLE_CYC - 1);

   typedef enum logic [1:0] {
      IDLE,
      BOUNCE,
      SETTLE
   } state_e;

   state_e           state_q, state_d;
   logic [15:0]      lfsr_q, lfsr_d;
   logic [SEG_W-1:0] seg_q, seg_d;
   logic [TOG_W-1:0] tog_q, tog_d;
   logic [ST_W-1:0]  set_q, set_d;
   logic             tgt_q, tgt_d;
   logic             sw_q, sw_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [7:0]       edge_q, edge_d;

   logic             lfsr_fb;
   logic [15:0]      lfsr_nxt;

   // x^16+x^14+x^13+x^11+1, shifting left with feedback entering at bit 0
   assign lfsr_fb  = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
   assign lfsr_nxt = {lfsr_q[14:0], lfsr_fb};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         lfsr_q  <= SEED;
         seg_q   <= '0;
         tog_q   <= '0;
         set_q   <= '0;
         tgt_q   <= 1'b0;
         sw_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         edge_q  <= '0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         seg_q   <= seg_d;
         tog_q   <= tog_d;
         set_q   <= set_d;
         tgt_q   <= tgt_d;
         sw_q    <= sw_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         edge_q  <= edge_d;
      end
   end

   // seg_q holds L-1 so a segment of length L spans L cycles ending at zero
   always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      seg_d   = seg_q;
      tog_d   = tog_q;
      set_d   = set_q;
      tgt_d   = tgt_q;
      sw_d    = sw_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               tgt_d   = level;
               seg_d   = lfsr_q[SEG_W-1:0];
               lfsr_d  = lfsr_nxt;
               tog_d   = '0;
               busy_d  = 1'b1;
               state_d = BOUNCE;
            end
         end
         BOUNCE: begin
            if (seg_q != '0) begin
               seg_d = seg_q - SEG_W'(1);
            end else if (tog_q < TOG_MAX) begin
               sw_d   = ~sw_q;
               tog_d  = tog_q + TOG_W'(1);
               seg_d  = lfsr_q[SEG_W-1:0];
               lfsr_d = lfsr_nxt;
            end else begin
               sw_d    = tgt_q;
               set_d   = ST_LOAD;
               state_d = SETTLE;
            end
         end
         SETTLE: begin
            if (set_q != '0) begin
               set_d = set_q - ST_W'(1);
            end else begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      edge_d = edge_q + {7'd0, sw_d ^ sw_q};
   end

   assign sw_out   = sw_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign edge_cnt = edge_q;

endmodule

// File: tb/tb_bounce_gen.sv
// Directed bench for bounce_gen: vector table of operations plus reset and
// back-to-back wrap sequences, with an LFSR reference predicting segment lengths.
module tb_bounce_gen;

   localparam int          NB         = 2;
   localparam int          SEG_W      = 3;
   localparam int          SETTLE_CYC = 16;
   localparam logic [15:0] SEED       = 16'hACE1;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic       start = 1'b0;
   logic       level = 1'b0;
   logic       sw_out, busy, done;
   logic [7:0] edge_cnt;

   bounce_gen #(
      .NB(NB), .SEG_W(SEG_W), .SETTLE_CYC(SETTLE_CYC), .SEED(SEED)
   ) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .level(level),
      .sw_out(sw_out), .busy(busy), .done(done), .edge_cnt(edge_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [15:0] m_lfsr;
   logic        m_sw;
   int          m_edge;

   typedef struct {
      logic level;
      logic disturb;
      int   exp_edges;
      logic exp_final;
      int   exp_done_n;   // 0: take done offset from the reference model
   } vec_t;

   vec_t vecs[4];

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      logic fb;
      fb = v[15] ^ v[13] ^ v[12] ^ v[10];
      return {v[14:0], fb};
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_lfsr = SEED;
      m_sw   = 1'b0;
      m_edge = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      start   = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      model_reset();
   endtask

   // Entered and left on a negedge; a following call chains back-to-back.
   task automatic run_op(input string tag, input logic lvl, input logic disturb,
                         input int exp_edges, input logic exp_final, input int exp_done_tbl);
      int         seg_len [2*NB+1];
      int         bnd     [2*NB+2];
      int         sum, total, exp_done_n, n, done_n, ntog;
      int         sw_err, busy_err, done_err, edge_err;
      logic       s0, exp_sw, prev_sw;
      logic [7:0] e0, prev_e;

      s0  = m_sw;
      sum = 0;
      for (int i = 0; i <= 2*NB; i++) begin
         seg_len[i] = int'(m_lfsr[SEG_W-1:0]) + 1;
         m_lfsr     = lfsr_step(m_lfsr);
         sum       += seg_len[i];
         bnd[i+1]   = 1 + sum;
      end
      total      = sum + SETTLE_CYC;
      exp_done_n = (exp_done_tbl != 0) ? exp_done_tbl : total + 1;

      e0 = edge_cnt; prev_e = edge_cnt; prev_sw = sw_out;
      sw_err = 0; busy_err = 0; done_err = 0; edge_err = 0;
      level = lvl;
      start = 1'b1;
      @(posedge clk);
      done_n = -1;
      n = 0;
      while (done_n < 0 && n < total + 8) begin
         @(negedge clk);
         n++;
         if (n == 1) start = 1'b0;
         if (disturb && n == 2) begin start = 1'b1; level = 1'b0; end
         if (disturb && n == 3) start = 1'b0;
         ntog = 0;
         for (int k = 1; k <= 2*NB; k++) if (n >= bnd[k]) ntog++;
         exp_sw = (n >= bnd[2*NB+1]) ? lvl : (s0 ^ ntog[0]);
         if (sw_out !== exp_sw) sw_err++;
         if (busy !== (n <= total)) busy_err++;
         if (done !== (n == total + 1)) done_err++;
         if (edge_cnt !== 8'(prev_e + {7'd0, sw_out ^ prev_sw})) edge_err++;
         prev_sw = sw_out;
         prev_e  = edge_cnt;
         if (done === 1'b1) done_n = n;
      end
      m_edge += 2*NB + ((lvl != s0) ? 1 : 0);
      m_sw    = lvl;

      check({tag, " sw_out trace mismatches"}, sw_err, 0);
      check({tag, " busy trace mismatches"}, busy_err, 0);
      check({tag, " done trace mismatches"}, done_err, 0);
      check({tag, " edge_cnt step mismatches"}, edge_err, 0);
      check({tag, " done cycle after start"}, done_n, exp_done_n);
      check({tag, " transitions"}, int'(8'(edge_cnt - e0)), exp_edges);
      check({tag, " final sw_out"}, int'(sw_out), int'(exp_final));
      check({tag, " edge_cnt"}, int'(edge_cnt), m_edge % 256);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int w, dcount;

      // Hand-derived from SEED 0xACE1: op0 segments 2,4,8,8,7; op1 5,2,3,5,1
      vecs[0] = '{level: 1'b1, disturb: 1'b0, exp_edges: 5, exp_final: 1'b1, exp_done_n: 46};
      vecs[1] = '{level: 1'b1, disturb: 1'b0, exp_edges: 4, exp_final: 1'b1, exp_done_n: 33};
      vecs[2] = '{level: 1'b0, disturb: 1'b0, exp_edges: 5, exp_final: 1'b0, exp_done_n: 0};
      vecs[3] = '{level: 1'b1, disturb: 1'b1, exp_edges: 5, exp_final: 1'b1, exp_done_n: 0};

      #2 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset sw_out", int'(sw_out), 0);
      check("reset busy", int'(busy), 0);
      check("reset done", int'(done), 0);
      check("reset edge_cnt", int'(edge_cnt), 0);
      reset_n = 1'b1;
      model_reset();
      repeat (5) @(negedge clk);
      check("idle sw_out", int'(sw_out), 0);
      check("idle busy", int'(busy), 0);
      check("idle done", int'(done), 0);
      check("idle edge_cnt", int'(edge_cnt), 0);

      for (int i = 0; i < 4; i++)
         run_op($sformatf("vec%0d", i), vecs[i].level, vecs[i].disturb,
                vecs[i].exp_edges, vecs[i].exp_final, vecs[i].exp_done_n);

      // Reset mid-bounce while sw_out is high (starting from 1: 1->0->1)
      level = 1'b1;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      w = 0;
      while (sw_out !== 1'b0 && w < 40) begin @(negedge clk); w++; end
      while (sw_out !== 1'b1 && w < 40) begin @(negedge clk); w++; end
      check("pre-reset sw_out high", int'(sw_out), 1);
      check("pre-reset busy", int'(busy), 1);
      reset_n = 1'b0;
      #1;
      check("mid-op reset sw_out", int'(sw_out), 0);
      check("mid-op reset busy", int'(busy), 0);
      check("mid-op reset edge_cnt", int'(edge_cnt), 0);
      dcount = 0;
      repeat (4) begin
         @(negedge clk);
         if (done !== 1'b0) dcount++;
      end
      check("no done during reset", dcount, 0);
      reset_n = 1'b1;
      model_reset();
      @(negedge clk);
      run_op("post-reset", 1'b1, 1'b0, 5, 1'b1, 46);

      // 52 chained operations: 260 edges wrap edge_cnt to 4
      do_reset();
      for (int k = 0; k < 52; k++)
         run_op($sformatf("chain%0d", k), (k % 2 == 0), 1'b0, 5, (k % 2 == 0), 0);
      check("chain edge_cnt after wrap", int'(edge_cnt), 4);
      check("chain final sw_out", int'(sw_out), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
